// File: rtl/spm_ctrl_pkg.sv
// Shared sequencer states, register address defaults and the output saturator
// for the N-channel SPM offset mixer.
package spm_ctrl_pkg;

  localparam int MAXCH = 8;

  localparam logic [31:0] OFFSET_REG_ADDR     = 32'd1110;
  localparam logic [31:0] MODULATION_REG_ADDR = 32'd1111;
  localparam logic [31:0] CONTROL_REG_ADDR    = 32'd1112;

  // Symmetric range: -2^31 is never produced so downstream negation is safe.
  localparam logic signed [33:0] SAT_MAX = 34'sd2147483647;
  localparam logic signed [33:0] SAT_MIN = -34'sd2147483647;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    MODSCALE,
    CHAN,
    COMMIT
  } state_e;

  function automatic logic signed [31:0] sat32(input logic signed [33:0] x);
    logic signed [31:0] y;
    if (x > SAT_MAX) begin
      y = 32'sh7FFF_FFFF;
    end else if (x < SAT_MIN) begin
      y = 32'sh8000_0001;
    end else begin
      y = x[31:0];
    end
    return y;
  endfunction

endpackage

// File: rtl/spm_slew_adjuster.sv
// Single-step slew-limited offset adjuster; moves cur toward target by at most
// step per call, with snap/freeze overrides. Purely combinational.
module spm_slew_adjuster
  import spm_ctrl_pkg::*;
(
  input  logic signed [31:0] cur_i,
  input  logic signed [31:0] target_i,
  input  logic        [31:0] step_i,
  input  logic               freeze_i,
  input  logic               snap_i,
  output logic signed [31:0] next_o
);

  // Two guard bits: cur +/- a full 32-bit unsigned step cannot wrap.
  logic signed [33:0] cur_x;
  logic signed [33:0] tgt_x;
  logic signed [33:0] step_x;
  logic signed [33:0] p_x;
  logic signed [33:0] m_x;
  logic               unused_hi;

  always_comb begin
    cur_x  = 34'(cur_i);
    tgt_x  = 34'(target_i);
    step_x = {2'b00, step_i};
    p_x    = cur_x + step_x;
    m_x    = cur_x - step_x;
    next_o = cur_i;
    if (snap_i) begin
      next_o = target_i;
    end else if (freeze_i) begin
      next_o = cur_i;
    end else if (step_i == '0) begin
      next_o = target_i;
    end else if (tgt_x > p_x) begin
      next_o = p_x[31:0];
    end else if (tgt_x < m_x) begin
      next_o = m_x[31:0];
    end else begin
      next_o = target_i;
    end
  end

  // p/m are only selected when strictly inside the target's 32-bit range.
  assign unused_hi = ^{p_x[33:32], m_x[33:32]};

endmodule

// File: rtl/axis_spm_offset_mixer_n.sv
// NCH-channel SPM control mixer: tick-driven serial sweep of slew adjusters,
// GVP summands and lock-in injection, committed atomically with saturation.
module axis_spm_offset_mixer_n
  import spm_ctrl_pkg::*;
#(
  parameter int          NCH                    = 6,
  parameter int          RDECI                  = 5,
  parameter int          QSIGNALS               = 31,
  parameter int          SREF_DATA_WIDTH        = 25,
  parameter int          SREF_Q_WIDTH           = 24,
  parameter logic [31:0] offset_reg_address     = OFFSET_REG_ADDR,
  parameter logic [31:0] modulation_reg_address = MODULATION_REG_ADDR,
  parameter logic [31:0] control_reg_address    = CONTROL_REG_ADDR
) (
  input  logic                a_clk,
  input  logic                a_resetn,
  input  logic [31:0]         config_addr,
  input  logic [511:0]        config_data,
  input  logic [NCH*32-1:0]   S_AXIS_GVP_tdata,
  input  logic                S_AXIS_GVP_tvalid,
  input  logic [31:0]         S_AXIS_SREF_tdata,
  input  logic                S_AXIS_SREF_tvalid,
  output logic [NCH*32-1:0]   M_AXIS_tdata,
  output logic                M_AXIS_tvalid,
  output logic [NCH*32-1:0]   M_AXIS_OFFMON_tdata,
  output logic [NCH-1:0]      settled,
  output logic                busy
);

  localparam int IDXW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW     = SREF_DATA_WIDTH;
  localparam int MSHIFT = 2*SREF_Q_WIDTH - QSIGNALS;

  generate
    if (NCH < 1 || NCH > MAXCH || NCH + 4 > (1 << RDECI)) begin : g_param_check
      $error("axis_spm_offset_mixer_n: NCH=%0d does not fit in a 2^%0d update period", NCH, RDECI);
    end
  endgenerate

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [RDECI-1:0]  cnt_q;
  logic              tick_q;

  logic signed [31:0] target_q [NCH];
  logic        [31:0] step_q   [NCH];
  logic        [31:0] vol_q;
  logic     [NCH-1:0] inj_q;
  logic     [NCH-1:0] inv_q;
  logic         [1:0] ctrl_q;
  logic               snap_prev_q;
  logic               snap_req_q;

  logic signed [31:0] gvp_s_q  [NCH];
  logic signed [31:0] tgt_s_q  [NCH];
  logic        [31:0] step_s_q [NCH];
  logic     [NCH-1:0] inj_s_q;
  logic     [NCH-1:0] inv_s_q;
  logic               freeze_s_q;
  logic               snap_s_q;
  logic signed [2*SW-1:0] prod_q;
  logic signed [31:0] mod_q;

  logic signed [31:0] cur_q    [NCH];
  logic signed [31:0] sum_sh_q [NCH];
  logic     [NCH-1:0] settled_sh_q;

  logic signed [31:0] tdata_q  [NCH];
  logic signed [31:0] offmon_q [NCH];
  logic     [NCH-1:0] settled_q;
  logic               tvalid_q;

  // ---- register bus: level-sensitive writes and snap edge detection ----
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      for (int k = 0; k < NCH; k++) begin
        target_q[k] <= '0;
        step_q[k]   <= '0;
      end
      vol_q       <= '0;
      inj_q       <= '0;
      inv_q       <= '0;
      ctrl_q      <= '0;
      snap_prev_q <= 1'b0;
      snap_req_q  <= 1'b0;
    end else begin
      if (config_addr == offset_reg_address) begin
        for (int k = 0; k < NCH; k++) begin
          target_q[k] <= config_data[32*k +: 32];
          step_q[k]   <= config_data[32*(MAXCH+k) +: 32];
        end
      end
      if (config_addr == modulation_reg_address) begin
        vol_q <= config_data[31:0];
        inj_q <= config_data[32 +: NCH];
        inv_q <= config_data[64 +: NCH];
      end
      if (config_addr == control_reg_address) begin
        ctrl_q <= config_data[1:0];
      end
      snap_prev_q <= ctrl_q[1];
      // A fresh edge wins over the commit clear so it is never dropped.
      if (ctrl_q[1] && !snap_prev_q) begin
        snap_req_q <= 1'b1;
      end else if (state_q == COMMIT) begin
        snap_req_q <= 1'b0;
      end
    end
  end

  // ---- sequencer: tick generator and state register ----
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      cnt_q   <= cnt_q + RDECI'(1);
      tick_q  <= &cnt_q;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE:     if (tick_q) state_d = CAPTURE;
      CAPTURE:  state_d = MODSCALE;
      MODSCALE: begin
        state_d = CHAN;
        idx_d   = '0;
      end
      CHAN: begin
        if (idx_q == IDXW'(NCH-1)) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      COMMIT:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // ---- shared channel datapath ----
  logic signed [SW-1:0]   mv;
  logic signed [SW-1:0]   sref_s;
  logic signed [2*SW-1:0] prod_sh;
  logic signed [31:0]     a_cur, a_tgt, a_gvp, a_next;
  logic        [31:0]     a_step;
  logic                   a_inj, a_inv;
  logic signed [33:0]     mod_x, inj_x, sum_x;

  assign mv      = vol_q[31 -: SW];
  assign sref_s  = S_AXIS_SREF_tdata[SW-1:0];
  assign prod_sh = prod_q >>> MSHIFT;

  assign a_cur  = cur_q[idx_q];
  assign a_tgt  = tgt_s_q[idx_q];
  assign a_step = step_s_q[idx_q];
  assign a_gvp  = gvp_s_q[idx_q];
  assign a_inj  = inj_s_q[idx_q];
  assign a_inv  = inv_s_q[idx_q];

  spm_slew_adjuster u_adj (
    .cur_i    (a_cur),
    .target_i (a_tgt),
    .step_i   (a_step),
    .freeze_i (freeze_s_q),
    .snap_i   (snap_s_q),
    .next_o   (a_next)
  );

  always_comb begin
    mod_x = 34'(mod_q);
    inj_x = '0;
    if (a_inj) begin
      inj_x = a_inv ? -mod_x : mod_x;
    end
    sum_x = 34'(a_gvp) + 34'(a_next) + inj_x;
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      for (int k = 0; k < NCH; k++) begin
        gvp_s_q[k]  <= '0;
        tgt_s_q[k]  <= '0;
        step_s_q[k] <= '0;
        cur_q[k]    <= '0;
        sum_sh_q[k] <= '0;
        tdata_q[k]  <= '0;
        offmon_q[k] <= '0;
      end
      inj_s_q      <= '0;
      inv_s_q      <= '0;
      freeze_s_q   <= 1'b0;
      snap_s_q     <= 1'b0;
      prod_q       <= '0;
      mod_q        <= '0;
      settled_sh_q <= '0;
      settled_q    <= '0;
      tvalid_q     <= 1'b0;
    end else begin
      case (state_q)
        CAPTURE: begin
          for (int k = 0; k < NCH; k++) begin
            gvp_s_q[k]  <= S_AXIS_GVP_tdata[32*k +: 32];
            tgt_s_q[k]  <= target_q[k];
            step_s_q[k] <= step_q[k];
          end
          inj_s_q    <= inj_q;
          inv_s_q    <= inv_q;
          freeze_s_q <= ctrl_q[0];
          snap_s_q   <= snap_req_q;
          prod_q     <= mv * sref_s;
        end
        MODSCALE: mod_q <= prod_sh[31:0];
        CHAN: begin
          cur_q[idx_q]        <= a_next;
          sum_sh_q[idx_q]     <= sat32(sum_x);
          settled_sh_q[idx_q] <= (a_next == a_tgt);
        end
        COMMIT: begin
          for (int k = 0; k < NCH; k++) begin
            tdata_q[k]  <= sum_sh_q[k];
            offmon_q[k] <= cur_q[k];
          end
          settled_q <= settled_sh_q;
          tvalid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    M_AXIS_tdata        = '0;
    M_AXIS_OFFMON_tdata = '0;
    for (int k = 0; k < NCH; k++) begin
      M_AXIS_tdata[32*k +: 32]        = tdata_q[k];
      M_AXIS_OFFMON_tdata[32*k +: 32] = offmon_q[k];
    end
  end

  assign M_AXIS_tvalid = tvalid_q;
  assign settled       = settled_q;

  // Stream valids are ignored; low volume bits and the high product bits fall outside the Q31 result.
  logic unused_ok;
  assign unused_ok = ^{S_AXIS_GVP_tvalid, S_AXIS_SREF_tvalid, S_AXIS_SREF_tdata,
                       config_data, vol_q, prod_sh};

endmodule
